spi_regfile_sync: RTL and testbench

- Parametrised successor to the current SPI register set. SPI slave register file running entirely in the system `clk` domain.
- `spi_clk`, `spi_cs` and `spi_mosi` are oversampled. No SPI-clock-domain state, no `cs`-as-async-reset.
- Provides NREG registers of DATA_W bits, read-only status mapping, per-register write/read strobes and abort detection.
- Sits between the MCU SPI port and all mode/control consumers (LED, mux, 4094, sample-count logic).

---
 rtl/spi_regfile_sync_if.sv | 11 +
 rtl/spi_regfile_sync.sv | 211 +++++++++++++++++++++
 tb/tb_spi_regfile_sync.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_sync_if.sv
// SPI pin bundle between an MCU master and the oversampled register-file slave.
// The slave runs entirely in its own system clock domain.
interface spi_regfile_sync_if;
    logic spi_clk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_clk, output spi_cs, output spi_mosi, input spi_miso);
    modport slave  (input spi_clk, input spi_cs, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_regfile_sync.sv
// SPI mode-0 slave register file; all SPI pins are oversampled in the clk domain.
// Frame: HDR_W header bits (R/W flag + address), then DATA_W full-duplex data bits.
module spi_regfile_sync #(
    parameter int                     DATA_W   = 32,
    parameter int                     ADDR_W   = 7,
    parameter int                     NREG     = 16,
    parameter logic [NREG*DATA_W-1:0] INIT     = '0,
    parameter logic [NREG-1:0]        RO_MASK  = '0,
    parameter logic [31:0]            UNMAPPED = 32'h0F0F0F0F
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_regfile_sync_if.slave        spi,
    output logic [NREG*DATA_W-1:0]   regs_out,
    input  logic [NREG*DATA_W-1:0]   status_in,
    output logic [NREG-1:0]          wr_strobe,
    output logic [NREG-1:0]          rd_strobe,
    output logic                     xfer_err
);
    localparam int               HDR_W     = ADDR_W + 1;
    localparam int               IDX_W     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0]       HDR_LAST  = 8'(HDR_W - 1);
    localparam logic [7:0]       DATA_LAST = 8'(HDR_W + DATA_W - 1);
    localparam logic [DATA_W-1:0] UNMAP_V  = DATA_W'(UNMAPPED);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_DONE} state_t;

    state_t              state_r, state_next;
    logic [2:0]          sck_sync_r, cs_sync_r;
    logic [1:0]          mosi_sync_r;
    logic [7:0]          cnt_r;
    logic [HDR_W-2:0]    hdr_r;
    logic [DATA_W-2:0]   rx_r;
    logic [DATA_W-1:0]   tx_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                rd_flag_r, mapped_r, miso_r, xfer_err_r, commit_r;
    logic [NREG-1:0]     wr_strobe_r, rd_strobe_r;
    logic [IDX_W-1:0]    commit_idx_r;
    logic [DATA_W-1:0]   commit_data_r;
    logic [DATA_W-1:0]   regs_r [NREG];

    logic                sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
    logic                hdr_done_s, data_done_s, abort_s, write_ok_s, hdr_mapped_s;
    logic [HDR_W-1:0]    hdr_next_s;
    logic [DATA_W-1:0]   rx_next_s, rd_value_s;
    logic [ADDR_W-1:0]   hdr_addr_s;
    logic [IDX_W-1:0]    addr_idx_s;

    function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign sck_rise_s   = sck_sync_r[1] & ~sck_sync_r[2];
    assign sck_fall_s   = ~sck_sync_r[1] & sck_sync_r[2];
    assign cs_rise_s    = cs_sync_r[1] & ~cs_sync_r[2];
    assign cs_fall_s    = ~cs_sync_r[1] & cs_sync_r[2];
    assign hdr_next_s   = {hdr_r, mosi_sync_r[1]};
    assign rx_next_s    = {rx_r, mosi_sync_r[1]};
    assign hdr_addr_s   = hdr_next_s[ADDR_W-1:0];
    assign hdr_mapped_s = ({1'b0, hdr_addr_s} < (ADDR_W + 1)'(NREG));
    assign addr_idx_s   = IDX_W'(addr_r);
    assign write_ok_s   = data_done_s & ~rd_flag_r & mapped_r & ~RO_MASK[addr_idx_s];

    // Pin synchronisers. cs resets low so a frame already running at reset release
    // produces no falling event and is ignored until cs goes high again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_r  <= 3'b000;
            cs_sync_r   <= 3'b000;
            mosi_sync_r <= 2'b00;
        end else begin
            sck_sync_r  <= {sck_sync_r[1:0], spi.spi_clk};
            cs_sync_r   <= {cs_sync_r[1:0], spi.spi_cs};
            mosi_sync_r <= {mosi_sync_r[0], spi.spi_mosi};
        end
    end

    // Register read mux for the header-complete cycle; RO registers read status_in live.
    always_comb begin
        rd_value_s = UNMAP_V;
        for (int i = 0; i < NREG; i++) begin
            rd_value_s = (hdr_addr_s == ADDR_W'(i))
                       ? (RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs_r[i])
                       : rd_value_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; a final data bit coinciding with cs rising still commits.
    always_comb begin
        state_next  = state_r;
        hdr_done_s  = 1'b0;
        data_done_s = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: state_next = cs_fall_s ? ST_HDR : ST_IDLE;
            ST_HDR: begin
                hdr_done_s = sck_rise_s & ~cs_rise_s & (cnt_r == HDR_LAST);
                if (cs_rise_s) begin
                    abort_s    = (cnt_r != 8'd0);
                    state_next = ST_IDLE;
                end else if (hdr_done_s) begin
                    state_next = ST_DATA;
                end else begin
                    state_next = ST_HDR;
                end
            end
            ST_DATA: begin
                data_done_s = sck_rise_s & (cnt_r == DATA_LAST);
                if (data_done_s) begin
                    state_next = cs_rise_s ? ST_IDLE : ST_DONE;
                end else if (cs_rise_s) begin
                    abort_s    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_DONE: state_next = cs_rise_s ? ST_IDLE : ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Shift/decode datapath, strobes and the one-cycle-delayed commit request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= 8'd0;
            hdr_r         <= '0;
            rx_r          <= '0;
            tx_r          <= '0;
            addr_r        <= '0;
            rd_flag_r     <= 1'b0;
            mapped_r      <= 1'b0;
            miso_r        <= 1'b0;
            wr_strobe_r   <= '0;
            rd_strobe_r   <= '0;
            xfer_err_r    <= 1'b0;
            commit_r      <= 1'b0;
            commit_idx_r  <= '0;
            commit_data_r <= '0;
        end else begin
            wr_strobe_r <= '0;
            rd_strobe_r <= '0;
            xfer_err_r  <= abort_s;
            commit_r    <= 1'b0;
            if (state_r == ST_IDLE) begin
                cnt_r <= 8'd0;
                hdr_r <= '0;
                rx_r  <= '0;
            end else if (sck_rise_s && state_r != ST_DONE) begin
                cnt_r <= (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
            end
            if (state_r == ST_HDR && sck_rise_s) begin
                hdr_r <= hdr_next_s[HDR_W-2:0];
            end
            if (state_r == ST_DATA && sck_rise_s) begin
                rx_r <= rx_next_s[DATA_W-2:0];
            end
            if (hdr_done_s) begin
                tx_r        <= rd_value_s;
                addr_r      <= hdr_addr_s;
                rd_flag_r   <= hdr_next_s[HDR_W-1];
                mapped_r    <= hdr_mapped_s;
                rd_strobe_r <= hdr_mapped_s ? onehot(IDX_W'(hdr_addr_s)) : '0;
            end else if (state_r == ST_DATA && sck_fall_s) begin
                tx_r <= {tx_r[DATA_W-2:0], 1'b0};
            end
            miso_r <= (state_r == ST_DATA && state_next == ST_DATA)
                    ? (sck_fall_s ? tx_r[DATA_W-1] : miso_r) : 1'b0;
            if (write_ok_s) begin
                wr_strobe_r   <= onehot(addr_idx_s);
                commit_r      <= 1'b1;
                commit_idx_r  <= addr_idx_s;
                commit_data_r <= rx_next_s;
            end
        end
    end

    // Register storage; the write lands the cycle after its wr_strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= INIT[i*DATA_W +: DATA_W];
            end
        end else if (commit_r) begin
            regs_r[commit_idx_r] <= commit_data_r;
        end
    end

    // Flatten register array onto the output bus.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_out[i*DATA_W +: DATA_W] = regs_r[i];
        end
    end

    assign spi.spi_miso = miso_r;
    assign wr_strobe    = wr_strobe_r;
    assign rd_strobe    = rd_strobe_r;
    assign xfer_err     = xfer_err_r;
endmodule

// File: tb/tb_spi_regfile_sync.sv
// Directed bench for spi_regfile_sync: bit-banged mode-0 frames with hand-computed
// expectations for write/read, INIT, RO, unmapped, abort and mid-frame reset cases.
module tb_spi_regfile_sync;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;
    localparam logic [NR*DW-1:0] P_INIT = (512'h99990009 << (9*DW))
                                        | (512'h55550008 << (8*DW))
                                        | (512'h00AAAAAF << (7*DW));
    localparam logic [NR-1:0] P_RO = 16'h0008;

    logic             clk;
    logic             rst;
    logic [NR*DW-1:0] regs_out;
    logic [NR*DW-1:0] status_in;
    logic [NR-1:0]    wr_strobe;
    logic [NR-1:0]    rd_strobe;
    logic             xfer_err;

    spi_regfile_sync_if spi();

    spi_regfile_sync #(
        .DATA_W(DW), .ADDR_W(AW), .NREG(NR), .INIT(P_INIT), .RO_MASK(P_RO),
        .UNMAPPED(32'h0F0F0F0F)
    ) dut (
        .clk(clk), .rst(rst), .spi(spi), .regs_out(regs_out), .status_in(status_in),
        .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .xfer_err(xfer_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_hits [NR] = '{default: 0};
    int rd_hits [NR] = '{default: 0};
    int err_hits     = 0;
    int wr_base [NR];
    int rd_base [NR];
    int err_base;

    // Strobe pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            wr_hits[i] += int'(wr_strobe[i]);
            rd_hits[i] += int'(rd_strobe[i]);
        end
        err_hits += int'(xfer_err);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    task automatic snap();
        for (int i = 0; i < NR; i++) begin
            wr_base[i] = wr_hits[i];
            rd_base[i] = rd_hits[i];
        end
        err_base = err_hits;
    endtask

    function automatic int wr_delta(input int i);
        return wr_hits[i] - wr_base[i];
    endfunction

    function automatic int rd_delta(input int i);
        return rd_hits[i] - rd_base[i];
    endfunction

    function automatic int wr_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += wr_hits[i] - wr_base[i];
        return s;
    endfunction

    function automatic int rd_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += rd_hits[i] - rd_base[i];
        return s;
    endfunction

    task automatic half_bit();
        repeat (8) @(negedge clk);
    endtask

    // One mode-0 bit: mosi set while sck low, miso captured at the rising edge.
    task automatic spi_bit(input logic b, output logic m);
        spi.spi_mosi = b;
        half_bit();
        spi.spi_clk = 1'b1;
        m = spi.spi_miso;
        half_bit();
        spi.spi_clk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [39:0] frame, input int nbits, output logic [31:0] rx);
        logic m;
        rx = '0;
        spi.spi_cs = 1'b0;
        half_bit();
        for (int i = 0; i < nbits; i++) begin
            spi_bit(frame[39-i], m);
            if (i >= 8) rx = {rx[30:0], m};
        end
        half_bit();
        spi.spi_cs = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    logic [31:0]      rx;
    logic             mbit;
    logic [NR*DW-1:0] regs_snap;

    initial begin
        rst          = 1'b1;
        spi.spi_clk  = 1'b0;
        spi.spi_cs   = 1'b1;
        spi.spi_mosi = 1'b0;
        status_in    = '0;
        status_in[3*DW +: DW] = 32'hCAFEBABE;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        check_val("rst_miso", spi.spi_miso, 1'b0);
        check_val("rst_reg8", reg_of(8), 32'h55550008);
        check_val("rst_reg0", reg_of(0), 32'h00000000);
        check_val("rst_err", xfer_err, 1'b0);
        check_val("rst_wrs", wr_strobe, 16'h0000);

        snap();
        spi_xfer(40'h08_12345678, 40, rx);
        check_val("wr8_rx", rx, 32'h55550008);
        check_val("wr8_reg", reg_of(8), 32'h12345678);
        check_val("wr8_wrs", wr_delta(8), 1);
        check_val("wr8_wrtot", wr_total(), 1);
        check_val("wr8_rds", rd_delta(8), 1);
        check_val("done_miso", spi.spi_miso, 1'b0);

        snap();
        spi_xfer(40'h88_00000000, 40, rx);
        check_val("rd8_rx", rx, 32'h12345678);
        check_val("rd8_wrtot", wr_total(), 0);
        check_val("rd8_reg", reg_of(8), 32'h12345678);

        snap();
        spi_xfer(40'h87_00000000, 40, rx);
        check_val("rd7_rx", rx, 32'h00AAAAAF);
        check_val("rd7_reg", reg_of(7), 32'h00AAAAAF);
        check_val("rd7_rds", rd_delta(7), 1);

        snap();
        spi_xfer(40'h03_11111111, 40, rx);
        check_val("ro3_rx", rx, 32'hCAFEBABE);
        check_val("ro3_reg", reg_of(3), 32'h00000000);
        check_val("ro3_wrtot", wr_total(), 0);
        check_val("ro3_rds", rd_delta(3), 1);

        snap();
        spi_xfer(40'h95_00000000, 40, rx);
        check_val("unm_rd_rx", rx, 32'h0F0F0F0F);
        check_val("unm_rd_rdtot", rd_total(), 0);
        regs_snap = regs_out;
        snap();
        spi_xfer(40'h15_FFFFFFFF, 40, rx);
        check_val("unm_wr_rx", rx, 32'h0F0F0F0F);
        check_val("unm_wr_wrtot", wr_total(), 0);
        check_val("unm_wr_regs", (regs_out == regs_snap), 1'b1);

        snap();
        spi.spi_cs = 1'b0;
        repeat (10) @(negedge clk);
        spi.spi_cs = 1'b1;
        repeat (10) @(negedge clk);
        check_val("cs_toggle_err", err_hits - err_base, 0);

        snap();
        spi_xfer(40'h09_DEADBEEF, 20, rx);
        check_val("abort_err", err_hits - err_base, 1);
        check_val("abort_reg9", reg_of(9), 32'h99990009);
        check_val("abort_wrtot", wr_total(), 0);

        snap();
        spi_xfer(40'h09_DEADBEEF, 40, rx);
        check_val("after_abort_rx", rx, 32'h99990009);
        check_val("after_abort_reg9", reg_of(9), 32'hDEADBEEF);
        check_val("after_abort_wrs", wr_delta(9), 1);
        check_val("after_abort_err", err_hits - err_base, 0);

        snap();
        spi.spi_cs = 1'b0;
        half_bit();
        for (int i = 0; i < 30; i++) begin
            spi_bit(1'(40'h08_AAAA5555 >> (39 - i)), mbit);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("midrst_reg8", reg_of(8), 32'h55550008);
        check_val("midrst_miso", spi.spi_miso, 1'b0);
        rst = 1'b0;
        for (int i = 30; i < 40; i++) begin
            spi_bit(1'(40'h08_AAAA5555 >> (39 - i)), mbit);
        end
        half_bit();
        spi.spi_cs = 1'b1;
        repeat (24) @(negedge clk);
        check_val("midrst_tail_reg8", reg_of(8), 32'h55550008);
        check_val("midrst_tail_wrtot", wr_total(), 0);
        check_val("midrst_tail_err", err_hits - err_base, 0);

        snap();
        spi_xfer(40'h88_00000000, 40, rx);
        check_val("post_rst_rx", rx, 32'h55550008);
        check_val("post_rst_rds", rd_delta(8), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
